// File: rtl/bank_sequencer.sv
// rtl/bank_sequencer.sv - fetch/decode/exec/writeback sequencer for the 16x16 register bank (optional TRAP_ILLEGAL_EN)
module bank_sequencer #(
  parameter int PC_REG = 0,
  parameter int DW     = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          imem_req,
  output logic [DW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [DW-1:0] imem_data,
  output logic [3:0]    src_reg,
  output logic [3:0]    dst_reg,
  output logic [3:0]    wr_reg,
  output logic [DW-1:0] wr_data,
  output logic          wr_en,
  output logic          pc_inc,
  output logic [DW-1:0] pc_data_in,
  input  logic [DW-1:0] pc_data_out,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [2:0]    alu_op,
  input  logic [DW-1:0] alu_result,
  output logic          busy,
  output logic          halted,
  output logic          illegal
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_MOV  = 4'h5;
  localparam logic [3:0] OP_LDI  = 4'h6;
  localparam logic [3:0] OP_JMP  = 4'h7;
  localparam logic [3:0] OP_BEQZ = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t        r_state;
  state_t        w_next;
  logic [15:0]   r_ir;
  logic [DW-1:0] r_result;
  logic          r_bz;

  logic [3:0]    w_op;
  logic [3:0]    w_dst;
  logic          w_is_write;
  logic          w_trap;
  logic [DW-1:0] w_pc_next;

  assign w_op       = r_ir[15:12];
  assign w_dst      = r_ir[11:8];
  assign w_is_write = (w_op >= OP_ADD) && (w_op <= OP_LDI);
  assign w_pc_next  = pc_data_out + DW'(1);

  assign src_reg = r_ir[7:4];
  assign dst_reg = r_ir[11:8];
  assign busy    = (r_state != S_IDLE) && (r_state != S_HALT);
  assign halted  = (r_state == S_HALT);

`ifdef TRAP_ILLEGAL_EN
  logic r_illegal;
  logic w_is_illegal;

  assign w_is_illegal = (w_op >= 4'h9) && (w_op <= 4'hE);
  assign w_trap       = w_is_illegal;
  assign illegal      = r_illegal;

  // Sticky illegal-opcode flag, raised while the offending instruction executes
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_illegal <= 1'b0;
    else if (r_state == S_EXEC && w_is_illegal)
      r_illegal <= 1'b1;
  end
`else
  assign w_trap  = 1'b0;
  assign illegal = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  // Instruction register, result register and BEQZ condition
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ir     <= '0;
      r_result <= '0;
      r_bz     <= 1'b0;
    end else begin
      if (r_state == S_FETCH && imem_ack)
        r_ir <= imem_data[15:0];
      if (r_state == S_EXEC) begin
        r_bz <= (b == '0);
        if (w_op == OP_LDI)
          r_result <= {{(DW-4){1'b0}}, r_ir[3:0]};
        else if (w_op >= OP_ADD && w_op <= OP_OR)
          r_result <= alu_result;
        else
          r_result <= a;
      end
    end
  end

  // Next-state logic; a trapped or HALT instruction parks in HALT after WB
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_FETCH;
      S_FETCH:  if (imem_ack) w_next = S_DECODE;
      S_DECODE: w_next = S_EXEC;
      S_EXEC:   w_next = S_WB;
      S_WB:     w_next = (w_op == OP_HALT || w_trap) ? S_HALT : S_FETCH;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_IDLE;
    endcase
  end

  // Outputs: fetch handshake, ALU select, and the one-cycle WB strobes
  always_comb begin
    imem_req   = 1'b0;
    imem_addr  = '0;
    alu_op     = 3'd0;
    wr_en      = 1'b0;
    wr_reg     = 4'd0;
    wr_data    = '0;
    pc_inc     = 1'b0;
    pc_data_in = '0;
    case (r_state)
      S_FETCH: begin
        imem_req  = 1'b1;
        imem_addr = pc_data_out;
      end
      S_DECODE, S_EXEC: begin
        case (w_op)
          OP_SUB:  alu_op = 3'd1;
          OP_AND:  alu_op = 3'd2;
          OP_OR:   alu_op = 3'd3;
          default: alu_op = 3'd0;
        endcase
      end
      S_WB: begin
        if (w_op != OP_HALT && !w_trap) begin
          if (w_is_write) begin
            wr_en   = 1'b1;
            wr_reg  = w_dst;
            wr_data = r_result;
            // A write to the PC register is itself the PC update
            if (w_dst != PC_REG[3:0]) begin
              pc_inc     = 1'b1;
              pc_data_in = w_pc_next;
            end
          end else begin
            pc_inc = 1'b1;
            if (w_op == OP_JMP || (w_op == OP_BEQZ && r_bz))
              pc_data_in = r_result;
            else
              pc_data_in = w_pc_next;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bank_sequencer.sv
// tb/tb_bank_sequencer.sv - directed table-driven bench for bank_sequencer with bank, ALU and imem models
module tb_bank_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic        imem_req, imem_ack;
  logic [15:0] imem_addr, imem_data;
  logic [3:0]  src_reg, dst_reg, wr_reg;
  logic [15:0] wr_data, pc_data_in, pc_data_out, a, b, alu_result;
  logic        wr_en, pc_inc, busy, halted, illegal;
  logic [2:0]  alu_op;

  bank_sequencer #(.PC_REG(0), .DW(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .src_reg(src_reg), .dst_reg(dst_reg), .wr_reg(wr_reg), .wr_data(wr_data),
    .wr_en(wr_en), .pc_inc(pc_inc), .pc_data_in(pc_data_in), .pc_data_out(pc_data_out),
    .a(a), .b(b), .alu_op(alu_op), .alu_result(alu_result),
    .busy(busy), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // register bank model
  logic [15:0] regs [0:15];
  logic        ld;
  logic [3:0]  ld_idx;
  logic [15:0] ld_val;
  assign a           = regs[src_reg];
  assign b           = regs[dst_reg];
  assign pc_data_out = regs[0];

  always @(posedge clk) begin
    if (ld) regs[ld_idx] <= ld_val;
    else begin
      if (wr_en)  regs[wr_reg] <= wr_data;
      if (pc_inc) regs[0]      <= pc_data_in;
    end
  end

  // ALU model
  always_comb begin
    case (alu_op)
      3'd1:    alu_result = b - a;
      3'd2:    alu_result = b & a;
      3'd3:    alu_result = b | a;
      default: alu_result = b + a;
    endcase
  end

  // instruction memory responder with programmable wait states
  logic [15:0] imem [0:65535];
  int          wait_n;
  int          rcnt = 0;
  logic        force_ack;

  always @(negedge clk) begin
    imem_data = imem[imem_addr];
    if (imem_req && rcnt == wait_n) begin
      imem_ack = 1'b1;
      rcnt     = 0;
    end else begin
      imem_ack = force_ack;
      rcnt     = imem_req ? rcnt + 1 : 0;
    end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic set_reg(input logic [3:0] idx, input logic [15:0] val);
    ld = 1'b1; ld_idx = idx; ld_val = val;
    @(negedge clk);
    ld = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [15:0] instr;
    logic        wr_en;
    logic [3:0]  wr_reg;
    logic [15:0] wr_data;
    logic        pc_inc;
    logic [15:0] pc_in;
    logic        halted;
    int          cycles;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int cnt, found, req_cnt, strobes;
    logic [15:0] first_pc;
    logic        first_wr;
    rst_n = 1'b0; start = 1'b0; ld = 1'b0; ld_idx = 4'd0; ld_val = 16'd0;
    force_ack = 1'b0; wait_n = 0;
    for (int i = 0; i < 65536; i++) imem[i] = 16'h0000;
    for (int i = 0; i < 16; i++) set_reg(i[3:0], 16'h0000);
    set_reg(4'd1, 16'h0040);
    set_reg(4'd5, 16'h0007);
    set_reg(4'd6, 16'h00F5);
    set_reg(4'd7, 16'h0003);
    set_reg(4'd9, 16'h0050);
    @(negedge clk); @(negedge clk);

    chk("rst_imem_req", imem_req, 0);
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_src_dst", {src_reg, dst_reg}, 0);
    chk("rst_wr", {wr_en, wr_reg, wr_data}, 0);
    chk("rst_pc", {pc_inc, pc_data_in}, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_flags", {busy, halted, illegal}, 0);

    //          addr      instr     we    wreg  wdata     pci   pc_in     halt cyc
    vecs[0]  = '{16'h0000, 16'h6305, 1'b1, 4'd3, 16'h0005, 1'b1, 16'h0001, 1'b0, 4};
    vecs[1]  = '{16'h0001, 16'h1330, 1'b1, 4'd3, 16'h000A, 1'b1, 16'h0002, 1'b0, 4};
    vecs[2]  = '{16'h0002, 16'h2370, 1'b1, 4'd3, 16'h0007, 1'b1, 16'h0003, 1'b0, 4};
    vecs[3]  = '{16'h0003, 16'h3630, 1'b1, 4'd6, 16'h0005, 1'b1, 16'h0004, 1'b0, 4};
    vecs[4]  = '{16'h0004, 16'h4610, 1'b1, 4'd6, 16'h0045, 1'b1, 16'h0005, 1'b0, 4};
    vecs[5]  = '{16'h0005, 16'h5810, 1'b1, 4'd8, 16'h0040, 1'b1, 16'h0006, 1'b0, 4};
    vecs[6]  = '{16'h0006, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b1, 16'h0007, 1'b0, 4};
    vecs[7]  = '{16'h0007, 16'h8510, 1'b0, 4'd0, 16'h0000, 1'b1, 16'h0008, 1'b0, 4};
    vecs[8]  = '{16'h0008, 16'h8210, 1'b0, 4'd0, 16'h0000, 1'b1, 16'h0040, 1'b0, 4};
    vecs[9]  = '{16'h0040, 16'h7090, 1'b0, 4'd0, 16'h0000, 1'b1, 16'h0050, 1'b0, 4};
    vecs[10] = '{16'h0050, 16'h6009, 1'b1, 4'd0, 16'h0009, 1'b0, 16'h0000, 1'b0, 4};
    vecs[11] = '{16'h0009, 16'hF000, 1'b0, 4'd0, 16'h0000, 1'b0, 16'h0000, 1'b1, 5};
    for (int i = 0; i < 12; i++) imem[vecs[i].addr] = vecs[i].instr;

    rst_n = 1'b1;
    @(negedge clk);
    pulse_start();
    chk("start_imem_req", imem_req, 1);
    chk("start_imem_addr", imem_addr, 16'h0000);
    chk("start_busy", busy, 1);

    for (int i = 0; i < 12; i++) begin
      cnt = (i == 0) ? 1 : 0;
      found = 0;
      for (int k = 0; k < 30 && found == 0; k++) begin
        @(negedge clk);
        cnt++;
        if (wr_en || pc_inc || halted) found = 1;
      end
      chk($sformatf("v%0d_seen", i), found, 1);
      chk($sformatf("v%0d_cycles", i), cnt, vecs[i].cycles);
      chk($sformatf("v%0d_wr_en", i), wr_en, vecs[i].wr_en);
      chk($sformatf("v%0d_pc_inc", i), pc_inc, vecs[i].pc_inc);
      chk($sformatf("v%0d_halted", i), halted, vecs[i].halted);
      if (vecs[i].wr_en) begin
        chk($sformatf("v%0d_wr_reg", i), wr_reg, vecs[i].wr_reg);
        chk($sformatf("v%0d_wr_data", i), wr_data, vecs[i].wr_data);
      end
      if (vecs[i].pc_inc)
        chk($sformatf("v%0d_pc_data_in", i), pc_data_in, vecs[i].pc_in);
    end

    // HALT is absorbing: start has no effect
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    chk("halt_stays", halted, 1);
    chk("halt_not_busy", {busy, imem_req}, 0);

    // wait states plus PC wrap at 0xFFFF
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    set_reg(4'd0, 16'hFFFF);
    wait_n = 3;
    pulse_start();
    req_cnt = 0; strobes = 0;
    for (int k = 0; k < 20; k++) begin
      if (!imem_req) break;
      req_cnt++;
      if (wr_en || pc_inc) strobes++;
      @(negedge clk);
    end
    chk("wait_req_cycles", req_cnt, 4);
    chk("wait_no_strobes", strobes, 0);
    @(negedge clk); @(negedge clk);
    chk("wrap_pc_inc", {wr_en, pc_inc}, 2'b01);
    chk("wrap_pc_data_in", pc_data_in, 16'h0000);
    strobes = 0;
    @(negedge clk);
    chk("wrap_next_addr", imem_addr, 16'h0000);
    @(negedge clk);
    if (wr_en || pc_inc) strobes++;
    chk("ack_once", strobes, 0);

    // reset in the middle of a fetch; later acks are ignored
    chk("midfetch_req", imem_req, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    force_ack = 1'b1;
    strobes = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (busy || imem_req || wr_en || pc_inc) strobes++;
    end
    force_ack = 1'b0;
    chk("rst_fetch_idle", strobes, 0);
    chk("rst_fetch_ir", {src_reg, dst_reg}, 0);

    // illegal opcode
    wait_n = 0;
    set_reg(4'd0, 16'h0020);
    imem[16'h0020] = 16'h9000;
    pulse_start();
    strobes = 0; first_pc = 16'hDEAD; first_wr = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if ((wr_en || pc_inc) && strobes == 0) begin
        first_pc = pc_data_in;
        first_wr = wr_en;
      end
      if (wr_en || pc_inc) strobes++;
    end
`ifdef TRAP_ILLEGAL_EN
    chk("trap_no_strobes", strobes, 0);
    chk("trap_illegal", illegal, 1);
    chk("trap_halted", halted, 1);
`else
    chk("ill_strobes", strobes, 1);
    chk("ill_pc_data_in", first_pc, 16'h0021);
    chk("ill_no_write", first_wr, 0);
    chk("ill_flag_low", {illegal, halted}, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
